// File: rtl/hp_fp_pkg.sv
// FP16 field layout, special encodings and exception codes
// shared by the half-precision adder datapath and its arbiter.
package hp_fp_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_HI   = 14;
  localparam int EXP_LO   = 10;
  localparam int MAN_HI   = 9;

  localparam logic [15:0] QNAN = 16'hFFFF;
  localparam logic [15:0] PINF = 16'h7C00;
  localparam logic [15:0] NINF = 16'hFC00;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_POVF = 2'b01;
  localparam logic [1:0] EXC_NOVF = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  function automatic logic is_nan(input logic [15:0] x);
    return (&x[EXP_HI:EXP_LO]) & (|x[MAN_HI:0]);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (&x[EXP_HI:EXP_LO]) & ~(|x[MAN_HI:0]);
  endfunction

  // Subnormals share the exponent of the smallest normal.
  function automatic logic [4:0] eff_exp(input logic [15:0] x);
    return (x[EXP_HI:EXP_LO] == 5'd0) ? 5'd1 : x[EXP_HI:EXP_LO];
  endfunction

  // Significand with hidden bit and three guard bits.
  function automatic logic [13:0] sig(input logic [15:0] x);
    return {x[EXP_HI:EXP_LO] != 5'd0, x[MAN_HI:0], 3'b000};
  endfunction

endpackage

// File: rtl/hp_adder.sv
// Combinational FP16 adder, round-to-nearest-even, saturating
// overflow to signed infinity with an exception code.
module hp_adder
  import hp_fp_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic [1:0]  exc
);

  logic [15:0] big, sml;
  logic [4:0]  e_big, e_sml, d;
  logic [13:0] m_big, m_sml, nrm;
  logic [14:0] raw, pk;
  logic [5:0]  e;
  logic        rnd, s_out, nan_c, inf_c;

  always_comb begin
    big   = a;
    sml   = b;
    if (a[14:0] < b[14:0]) begin
      big = b;
      sml = a;
    end
    e_big = eff_exp(big);
    e_sml = eff_exp(sml);
    d     = e_big - e_sml;
    m_big = sig(big);
    m_sml = (d > 5'd13) ? 14'd0 : (sig(sml) >> d);
    if (big[SIGN_BIT] == sml[SIGN_BIT])
      raw = {1'b0, m_big} + {1'b0, m_sml};
    else
      raw = {1'b0, m_big} - {1'b0, m_sml};

    e   = {1'b0, e_big};
    nrm = raw[13:0];
    if (raw[14]) begin
      nrm = raw[14:1];
      e   = e + 6'd1;
    end else begin
      for (int i = 0; i < 13; i++) begin
        if (!nrm[13] && e > 6'd1) begin
          nrm = nrm << 1;
          e   = e - 6'd1;
        end
      end
    end

    // Rounding carry may ripple into the exponent field.
    rnd   = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    pk    = {(nrm[13] ? e[4:0] : 5'd0), nrm[12:3]} + {14'd0, rnd};
    s_out = (raw == 15'd0) ? 1'b0 : big[SIGN_BIT];
    sum   = {s_out, pk};
    exc   = EXC_NONE;
    if (e >= 6'd31 || pk[14:10] == 5'd31) begin
      sum = s_out ? NINF : PINF;
      exc = s_out ? EXC_NOVF : EXC_POVF;
    end

    nan_c = is_nan(a) | is_nan(b)
          | (is_inf(a) & is_inf(b) & (a[SIGN_BIT] ^ b[SIGN_BIT]));
    inf_c = !nan_c && (is_inf(a) || is_inf(b));
    unique case (1'b1)
      nan_c: begin
        sum = QNAN;
        exc = EXC_NAN;
      end
      inf_c: begin
        sum = is_inf(a) ? a : b;
        exc = EXC_NONE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid index at or
// after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  always_comb begin
    int j;
    logic [ID_W-1:0] idx;
    j      = 0;
    idx    = '0;
    grant  = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = ID_W'(j);
      if (!any && valid[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = idx;
      end
    end
  end

endmodule

// File: rtl/hp_add_arbiter.sv
// Round-robin shared FP16 adder: operand stage, result stage,
// tagged response channel and saturating exception counters.
module hp_add_arbiter
  import hp_fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_sum,
  output logic [1:0]            rsp_exc,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      ovf_cnt,
  output logic [CNT_W-1:0]      nan_cnt
);

  logic              s1_valid, s2_valid;
  logic              s1_ready, s2_ready, s2_load, xfer;
  logic [15:0]       s1_a, s1_b, s2_sum, add_sum;
  logic [1:0]        s2_exc, add_exc;
  logic [ID_W-1:0]   s1_id, s2_id, rr_ptr, gnt_id;
  logic [NUM_REQ-1:0] grant;

  assign s2_ready = !s2_valid | rsp_ready;
  assign s1_ready = !s1_valid | s2_ready;
  assign s2_load  = s2_ready & s1_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .valid  (req_valid & {NUM_REQ{s1_ready}}),
    .ptr    (rr_ptr),
    .grant  (grant),
    .gnt_id (gnt_id),
    .any    (xfer)
  );

  hp_adder u_add (
    .a   (s1_a),
    .b   (s1_b),
    .sum (add_sum),
    .exc (add_exc)
  );

  assign req_ready = grant;
  assign rsp_valid = s2_valid;
  assign rsp_id    = s2_id;
  assign rsp_sum   = s2_sum;
  assign rsp_exc   = s2_exc;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (xfer) begin
      s1_valid <= 1'b1;
      s1_a     <= req_a[16*int'(gnt_id) +: 16];
      s1_b     <= req_b[16*int'(gnt_id) +: 16];
      s1_id    <= gnt_id;
      rr_ptr   <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0
                : gnt_id + ID_W'(1);
    end else if (s2_ready) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_exc   <= '0;
      s2_id    <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_sum   <= add_sum;
      s2_exc   <= add_exc;
      s2_id    <= s1_id;
    end else if (rsp_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Counted on the S2 load so a stalled result is seen only once.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ovf_cnt <= '0;
      nan_cnt <= '0;
    end else if (s2_load) begin
      if ((add_exc == EXC_POVF || add_exc == EXC_NOVF)
          && ovf_cnt != '1)
        ovf_cnt <= ovf_cnt + CNT_W'(1);
      if (add_exc == EXC_NAN && nan_cnt != '1)
        nan_cnt <= nan_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hp_add_arbiter.sv
// Directed bench for hp_add_arbiter: datapath cases, fairness,
// backpressure and reset while results are in flight.
module tb_hp_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_sum;
  logic [1:0]  rsp_exc;
  logic        cnt_clr;
  logic [15:0] ovf_cnt, nan_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] fair_sum [4] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500};

  always #5 clk = ~clk;

  hp_add_arbiter #(
    .NUM_REQ (4),
    .ID_W    (2),
    .CNT_W   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_exc   (rsp_exc),
    .cnt_clr   (cnt_clr),
    .ovf_cnt   (ovf_cnt),
    .nan_cnt   (nan_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int i, input logic [15:0] a,
                    input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id,
                         input logic [15:0] s, input logic [1:0] e);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"},    32'(rsp_id),    32'(id));
    chk({tag, "_sum"},   32'(rsp_sum),   32'(s));
    chk({tag, "_exc"},   32'(rsp_exc),   32'(e));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    cnt_clr   = 1'b0;
    step();
    step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_sum",   32'(rsp_sum),   32'd0);
    chk("rst_rsp_exc",   32'(rsp_exc),   32'd0);
    chk("rst_ovf",       32'(ovf_cnt),   32'd0);
    chk("rst_nan",       32'(nan_cnt),   32'd0);
    chk("rst_ready",     32'(req_ready), 32'd0);
    rst = 1'b0;

    // single add on requester 0
    op(0, 16'h4A21, 16'h4000);
    req_valid = 4'b0001;
    #1 chk("add_gnt", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("add_lat1", 32'(rsp_valid), 32'd0);
    step();
    chk_rsp("add", 2'd0, 16'h4B21, 2'b00);
    step();
    chk("add_drain", 32'(rsp_valid), 32'd0);

    // cancellation on requester 2, pointer now 1
    op(2, 16'h4A21, 16'hCA21);
    req_valid = 4'b0100;
    #1 chk("can_gnt", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    chk_rsp("can", 2'd2, 16'h0000, 2'b00);
    chk("can_ovf", 32'(ovf_cnt), 32'd0);
    chk("can_nan", 32'(nan_cnt), 32'd0);
    step();

    // overflow then NaN on requester 1, pointer now 3
    op(1, 16'h7794, 16'h7B2A);
    req_valid = 4'b0010;
    #1 chk("ovf_gnt", 32'(req_ready), 32'h2);
    step();
    op(1, 16'hF794, 16'hFF2A);
    #1 chk("nan_gnt", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    chk_rsp("ovf", 2'd1, 16'h7C00, 2'b01);
    chk("ovf_cnt1", 32'(ovf_cnt), 32'd1);
    chk("ovf_nan0", 32'(nan_cnt), 32'd0);
    step();
    chk_rsp("nan", 2'd1, 16'hFFFF, 2'b11);
    chk("nan_cnt1", 32'(nan_cnt), 32'd1);
    chk("nan_ovf1", 32'(ovf_cnt), 32'd1);
    step();
    chk("nan_drain", 32'(rsp_valid), 32'd0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_ovf", 32'(ovf_cnt), 32'd0);
    chk("clr_nan", 32'(nan_cnt), 32'd0);

    // requester 3 once, returning the pointer to 0
    op(3, 16'h3C00, 16'h3C00);
    req_valid = 4'b1000;
    #1 chk("r3_gnt", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    step();
    chk_rsp("r3", 2'd3, 16'h4000, 2'b00);

    // fairness: all four held valid for 8 cycles
    op(0, 16'h3C00, 16'h3C00);
    op(1, 16'h3C00, 16'h4000);
    op(2, 16'h3C00, 16'h4200);
    op(3, 16'h3C00, 16'h4400);
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = '0;
      #1;
      if (k < 8)
        chk("fair_gnt", 32'(req_ready), 32'(1) << (k % 4));
      if (k >= 2)
        chk_rsp("fair", 2'((k - 2) % 4), fair_sum[(k - 2) % 4], 2'b00);
      step();
    end
    chk("fair_drain", 32'(rsp_valid), 32'd0);

    // backpressure: three requesters, rsp_ready low for 5 cycles
    req_valid = 4'b0111;
    rsp_ready = 1'b0;
    #1 chk("bp_gnt0", 32'(req_ready), 32'h1);
    step();
    #1 chk("bp_gnt1", 32'(req_ready), 32'h2);
    step();
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_stall_gnt", 32'(req_ready), 32'h0);
      chk_rsp("bp_hold", 2'd0, 16'h4000, 2'b00);
      step();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_rel_gnt", 32'(req_ready), 32'h4);
    chk_rsp("bp_out0", 2'd0, 16'h4000, 2'b00);
    step();
    req_valid = '0;
    chk_rsp("bp_out1", 2'd1, 16'h4200, 2'b00);
    step();
    chk_rsp("bp_out2", 2'd2, 16'h4400, 2'b00);
    step();
    chk("bp_drain", 32'(rsp_valid), 32'd0);

    // reset while both stages hold results, pointer now 3
    op(3, 16'h7794, 16'h7B2A);
    op(1, 16'h3C00, 16'h3C00);
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    #1 chk("rm_gnt3", 32'(req_ready), 32'h8);
    step();
    #1 chk("rm_gnt1", 32'(req_ready), 32'h2);
    step();
    chk_rsp("rm_full", 2'd3, 16'h7C00, 2'b01);
    chk("rm_ovf", 32'(ovf_cnt), 32'd1);
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_valid", 32'(rsp_valid), 32'd0);
    chk("rm_ovf0", 32'(ovf_cnt), 32'd0);
    chk("rm_nan0", 32'(nan_cnt), 32'd0);
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    #1 chk("rm_gnt_after", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    chk("rm_no_ghost", 32'(rsp_valid), 32'd0);
    step();
    chk_rsp("rm_out", 2'd1, 16'h4000, 2'b00);
    step();
    chk("rm_drain", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hp_add_arbiter.md
Name: hp_add_arbiter

Overview:
- Shares one combinational hp_adder datapath between NUM_REQ independent requesters.
- Arbitration is round-robin with a valid/ready handshake on each requester.
- The adder is wrapped in a 2-stage registered pipeline: operand register, then result register. Results return on one tagged response channel with backpressure.
- Keeps saturating overflow and NaN event counters for system-level status readout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must equal clog2(NUM_REQ).
- CNT_W, 16, width of each exception event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept; at most one bit high.
- req_a  in  16*NUM_REQ  packed FP16 operand A; requester i uses bits [16i+15:16i].
- req_b  in  16*NUM_REQ  packed FP16 operand B, same packing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_sum  out  16  FP16 sum from hp_adder.
- rsp_exc  out  2  hp_adder exception code: 00 none/inf, 01 +overflow, 10 -overflow, 11 NaN.
- cnt_clr  in  1  synchronous clear of both counters.
- ovf_cnt  out  CNT_W  saturating count of results with exc 01 or 10.
- nan_cnt  out  CNT_W  saturating count of results with exc 11.

Behaviour:
- Reset values: all outputs 0. Internal state also resets: s1_valid, s2_valid and rr_ptr are 0.
- Pipeline ready chain:
  - s2_ready = !s2_valid | rsp_ready.
  - s1_ready = !s1_valid | s2_ready.
- Arbitration, purely combinational from current state:
  - Candidate set = req_valid when s1_ready, otherwise empty.
  - Grant goes to the first valid index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready = one-hot grant; zero when nothing is granted.
- Transfer on requester i occurs when req_valid[i] & req_ready[i]. The requester must hold valid and data stable until that transfer. Dropping valid before transfer is legal and causes no grant.
- rr_ptr updates to (granted index + 1) mod NUM_REQ on each transfer. It is unchanged when there is no transfer. A held requester therefore cannot be starved for more than NUM_REQ-1 grants.
- Stage S1:
  - On transfer, load s1_a, s1_b and s1_id, and set s1_valid.
  - Else if s2_ready, clear s1_valid.
  - Otherwise hold.
- hp_adder is fed from s1_a and s1_b only; its outputs are never registered elsewhere.
- Stage S2:
  - When s2_ready and s1_valid, load sum, exc and id, and set s2_valid.
  - Else if rsp_ready, clear s2_valid.
  - rsp_* are driven directly from the S2 registers.
- While rsp_valid & !rsp_ready, rsp_id, rsp_sum and rsp_exc stay stable.
- Timing: latency is 2 cycles from transfer to rsp_valid. Throughput is 1 result per cycle with rsp_ready held high.
- Full pipe with rsp_ready low: S1 and S2 both hold and req_ready is all zero. When rsp_ready rises, the S2 result drains, S1 moves to S2 and a new grant occurs, all in the same cycle.
- Counters:
  - Increment on the S2 load cycle only; a stalled S2 does not count.
  - Saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle.
- Reset asserted mid-operation discards all in-flight results with no response, clears the counters and returns rr_ptr to 0.
- Ordering: results leave in grant order. No reordering and no per-requester credit are needed.

Decomposition:
- Shared package hp_fp_pkg holds:
  - FP16 field constants (sign bit 15, exponent [14:10], mantissa [9:0]).
  - Canonical NaN 16'hFFFF and +/-Inf 16'h7C00 / 16'hFC00.
  - Exception code localparams EXC_NONE, EXC_POVF, EXC_NOVF, EXC_NAN.
- One sub-module, rr_arbiter: parameterised NUM_REQ, combinational grant from valid and rr_ptr. It is instanced once alongside hp_adder.

Test Plan:
- Single add, req0, a=16'h4A21 (12.26), b=16'h4000 (2.0), rsp_ready=1 -> 2 cycles later rsp_valid=1, rsp_id=0, rsp_sum=16'h4B21, rsp_exc=00.
- Cancellation, req2, a=16'h4A21, b=16'hCA21 -> rsp_sum=16'h0000, rsp_exc=00; counters unchanged.
- Overflow then NaN:
  - req1, a=16'h7794, b=16'h7B2A -> rsp_sum=16'h7C00, exc=01, ovf_cnt=1.
  - Then a=16'hF794, b=16'hFF2A -> rsp_sum=16'hFFFF, exc=11, nan_cnt=1.
  - cnt_clr pulse -> both counters 0.
- Fairness: all 4 requesters hold valid for 8 cycles, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order, one result per cycle.
- Backpressure: 3 back-to-back grants, rsp_ready=0 for 5 cycles -> exactly 2 transfers accepted, rsp_* stable, req_ready all zero. On release, results drain in grant order with no loss or duplication.
- Reset mid-flight: rst pulsed for 1 cycle while S1 and S2 are valid -> rsp_valid=0 the next cycle, counters 0, and the next grant goes to the lowest valid index starting from 0.
